// File: rtl/cdc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_arb_pkg
// Description : Shared types and helpers for the cdc_src_arbiter block.
//               state_e   - arbiter output-register state (IDLE / BUSY)
//               rr_idx_w  - width of a requester index, never below 1 bit
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int rr_idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_src_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdc_src_arbiter_if
// Description : Requester-side and CDC-side signals of cdc_src_arbiter.
//               slave  - seen by the arbiter
//               master - seen by the requesters / CDC source port
//   req_valid_i [NUM_REQ]         per-requester valid
//   req_ready_o [NUM_REQ]         per-requester accept, one-hot or zero
//   req_data_i  [NUM_REQ][DATA_W] per-requester payload
//   out_valid_o / out_ready_i     handshake towards cdc_4phase source side
//   out_data_o  [DATA_W]          registered payload
//   out_idx_o   [IDX_W]           registered index of the granted requester
//   wdog_err_o                    sticky stall error
// Revision    : 1.0 - initial release
// ============================================================================
interface cdc_src_arbiter_if
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
) ();

    localparam int IDX_W = rr_idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic [DATA_W-1:0]              out_data_o;
    logic [IDX_W-1:0]               out_idx_o;
    logic                           wdog_err_o;

    modport slave (
        input  req_valid_i, req_data_i, out_ready_i,
        output req_ready_o, out_valid_o, out_data_o, out_idx_o, wdog_err_o
    );

    modport master (
        output req_valid_i, req_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_data_o, out_idx_o, wdog_err_o
    );

endinterface
`default_nettype wire

// File: rtl/cdc_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : cdc_arb_rr_pick
// Description : Combinational round-robin pick. Returns the first set bit of
//               valid_i searching from ptr_i upwards, wrapping modulo NUM_REQ.
//   valid_i     [NUM_REQ] request vector
//   ptr_i       [IDX_W]   highest-priority index (must be < NUM_REQ)
//   gnt_valid_o           any request present
//   gnt_idx_o   [IDX_W]   index of the winner (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  wire logic [NUM_REQ-1:0] valid_i,
    input  wire logic [IDX_W-1:0]   ptr_i,
    output logic                    gnt_valid_o,
    output logic [IDX_W-1:0]        gnt_idx_o
);

    int               w_pos;
    logic [IDX_W-1:0] w_cand;

    // Walk the rotated order from lowest priority to highest so that the
    // last hit (the closest one to ptr_i) is the one that sticks.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        w_pos       = 0;
        w_cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(ptr_i) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_cand = IDX_W'(w_pos);
            if (valid_i[w_cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdc_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_src_arbiter
// Description : Round-robin arbiter sharing the source side of one cdc_4phase
//               channel among NUM_REQ requesters. The winner's payload and
//               index are registered so the CDC sees stable data/valid.
//   clk_i   source-domain clock
//   rst_ni  asynchronous active-low reset
//   bus     cdc_src_arbiter_if.slave (requester and CDC-side handshakes)
// Optional    : CDC_SRC_ARBITER_WDOG_EN - stall watchdog raising a sticky
//               wdog_err_o after WDOG_CYCLES stalled BUSY cycles; otherwise
//               wdog_err_o is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_src_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 64,
    parameter int WDOG_CYCLES = 1024
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    cdc_src_arbiter_if.slave  bus
);

    localparam int IDX_W = rr_idx_w(NUM_REQ);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [DATA_W-1:0]  out_data_q;
    logic [IDX_W-1:0]   out_idx_q;

    logic               w_gnt_valid;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_free;
    logic               w_accept;

    cdc_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i     (bus.req_valid_i),
        .ptr_i       (ptr_q),
        .gnt_valid_o (w_gnt_valid),
        .gnt_idx_o   (w_gnt_idx)
    );

    // In BUSY out_valid_o is high, so out_ready_i alone marks the handshake.
    // rst_ni gates the accept so no requester sees ready while in reset.
    assign w_free   = (state_q == IDLE) || bus.out_ready_i;
    assign w_accept = w_free && w_gnt_valid && rst_ni;

    assign ptr_d = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                       : w_gnt_idx + IDX_W'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept) state_d = BUSY;
            BUSY:    if (bus.out_ready_i && !w_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.out_valid_o = (state_q == BUSY);
        bus.req_ready_o = '0;
        if (w_accept) begin
            bus.req_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    // ---------------- Output register and priority pointer ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q <= '0;
            out_idx_q  <= '0;
            ptr_q      <= '0;
        end else if (w_accept) begin
            out_data_q <= bus.req_data_i[w_gnt_idx];
            out_idx_q  <= w_gnt_idx;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.out_data_o = out_data_q;
    assign bus.out_idx_o  = out_idx_q;

`ifdef CDC_SRC_ARBITER_WDOG_EN
    localparam int                c_wdog_w    = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_max  = c_wdog_w'(WDOG_CYCLES);
    localparam logic [c_wdog_w-1:0] c_wdog_trip = c_wdog_w'(WDOG_CYCLES - 1);

    logic [c_wdog_w-1:0] wdog_cnt_q;
    logic                wdog_err_q;
    logic                w_stall;

    assign w_stall = (state_q == BUSY) && !bus.out_ready_i;

    // The error is set on the edge where the count reaches WDOG_CYCLES,
    // i.e. at the end of the WDOG_CYCLES-th consecutive stalled cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else if (w_stall) begin
            if (wdog_cnt_q != c_wdog_max) begin
                wdog_cnt_q <= wdog_cnt_q + c_wdog_w'(1);
            end
            if (wdog_cnt_q >= c_wdog_trip) begin
                wdog_err_q <= 1'b1;
            end
        end else begin
            wdog_cnt_q <= '0;
        end
    end

    assign bus.wdog_err_o = wdog_err_q;
`else
    assign bus.wdog_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdc_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_src_arbiter
// Description : Self-checking bench for cdc_src_arbiter (NUM_REQ=4, DATA_W=64,
//               WDOG_CYCLES=8). Fixed vector table, hand-written corner
//               sequences and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_src_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int WD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cdc_src_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    cdc_src_arbiter #(
        .NUM_REQ     (N),
        .DATA_W      (DW),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state
    int          m_ptr;
    bit          m_busy;
    logic [63:0] m_data;
    int          m_idx;
    int          m_stall;
    bit          m_err;

    typedef struct {
        logic [3:0]  rv;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_idx;
        logic [63:0] e_data;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // First valid requester at or after p in circular order, -1 if none.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (((v >> ((p + k) % N)) & 4'b0001) != 4'b0000) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [255:0] rowdata(input int r);
        return {32'(r), 32'd3, 32'(r), 32'd2, 32'(r), 32'd1, 32'(r), 32'd0};
    endfunction

    function automatic logic [255:0] randdata();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle checked against the model; inputs already driven.
    task automatic mcycle(input string tag);
        bit          free;
        int          w;
        logic [3:0]  er;
        logic [255:0] flat;
        #1;
        free = !m_busy || bus.out_ready_i;
        w    = free ? pick(bus.req_valid_i, m_ptr) : -1;
        er   = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        chk({tag, " req_ready"}, 64'(bus.req_ready_o), 64'(er));
        chk({tag, " out_valid"}, 64'(bus.out_valid_o), 64'(m_busy));
        if (m_busy) begin
            chk({tag, " out_data"}, bus.out_data_o, m_data);
            chk({tag, " out_idx"}, 64'(bus.out_idx_o), 64'(m_idx));
        end
        chk({tag, " wdog_err"}, 64'(bus.wdog_err_o), 64'(m_err));
        flat = bus.req_data_i;
        @(posedge clk);
`ifdef CDC_SRC_ARBITER_WDOG_EN
        if (m_busy && !bus.out_ready_i) begin
            m_stall++;
            if (m_stall >= WD) m_err = 1'b1;
        end else begin
            m_stall = 0;
        end
`endif
        if (free) begin
            if (w >= 0) begin
                m_busy = 1'b1;
                m_data = 64'(flat >> (DW * w));
                m_idx  = w;
                m_ptr  = (w + 1) % N;
            end else begin
                m_busy = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid_i = 4'hF;
        bus.out_ready_i = 1'b1;
        bus.req_data_i  = rowdata(99);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("reset out_data", bus.out_data_o, 64'd0);
        chk("reset out_idx", 64'(bus.out_idx_o), 64'd0);
        chk("reset wdog_err", 64'(bus.wdog_err_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid_i = 4'h0;
        m_ptr = 0; m_busy = 1'b0; m_data = '0; m_idx = 0; m_stall = 0; m_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        //            rv     ordy  e_rdy    ov    idx    data
        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 64'h0};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 64'h0000_0000_0000_0002};
        tbl[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0, 64'h0};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 64'h0000_0002_0000_0003};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 64'h0000_0003_0000_0000};
        tbl[5]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd0, 64'h0000_0003_0000_0000};
        tbl[6]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 64'h0000_0005_0000_0001};
        tbl[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1, 64'h0000_0006_0000_0001};
        tbl[8]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd2, 64'h0000_0007_0000_0002};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 64'h0000_0008_0000_0001};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 64'h0000_0009_0000_0002};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0};

        bus.req_valid_i = '0;
        bus.out_ready_i = 1'b0;
        bus.req_data_i  = '0;
        @(negedge clk);

        // ---- vector table (includes single request and ptr=3 wrap) ----
        do_reset();
        for (int r = 0; r < 12; r++) begin
            bus.req_valid_i = tbl[r].rv;
            bus.out_ready_i = tbl[r].ordy;
            bus.req_data_i  = rowdata(r);
            #1;
            chk($sformatf("tbl%0d req_ready", r), 64'(bus.req_ready_o), 64'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d out_valid", r), 64'(bus.out_valid_o), 64'(tbl[r].e_ov));
            if (tbl[r].e_ov) begin
                chk($sformatf("tbl%0d out_idx", r), 64'(bus.out_idx_o), 64'(tbl[r].e_idx));
                chk($sformatf("tbl%0d out_data", r), bus.out_data_o, tbl[r].e_data);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // ---- round robin, all valid, ready high: 0,1,2,3,0 without bubble ----
        do_reset();
        bus.req_valid_i = 4'hF;
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.req_data_i = randdata();
            #1;
            chk($sformatf("rr grant %0d", k), 64'(bus.req_ready_o), 64'(4'b0001 << (k % N)));
            if (k > 0) chk($sformatf("rr valid %0d", k), 64'(bus.out_valid_o), 64'd1);
            mcycle($sformatf("rr%0d", k));
        end

        // ---- stall 20 cycles, then next grant goes to ptr (=1) ----
        do_reset();
        bus.req_valid_i = 4'hF;
        bus.out_ready_i = 1'b1;
        bus.req_data_i  = randdata();
        mcycle("stall_acc");
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.req_data_i = randdata();
            mcycle($sformatf("stall%0d", k));
        end
        bus.out_ready_i = 1'b1;
        #1;
        chk("stall release grant", 64'(bus.req_ready_o), 64'(4'b0010));
        mcycle("stall_rel");

        // ---- async reset mid-transfer ----
        do_reset();
        bus.req_valid_i = 4'b0001;
        bus.out_ready_i = 1'b0;
        bus.req_data_i  = randdata();
        mcycle("ar_acc");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("async rst out_data", bus.out_data_o, 64'd0);
        chk("async rst req_ready", 64'(bus.req_ready_o), 64'd0);

`ifdef CDC_SRC_ARBITER_WDOG_EN
        // ---- watchdog: error on the 8th stalled cycle, sticky ----
        do_reset();
        bus.req_valid_i = 4'b0001;
        bus.out_ready_i = 1'b0;
        bus.req_data_i  = randdata();
        mcycle("wd_acc");
        bus.req_valid_i = 4'b0000;
        for (int s = 1; s <= WD; s++) begin
            #1;
            chk($sformatf("wdog low stall%0d", s), 64'(bus.wdog_err_o), 64'd0);
            mcycle($sformatf("wd%0d", s));
        end
        #1;
        chk("wdog high", 64'(bus.wdog_err_o), 64'd1);
        bus.out_ready_i = 1'b1;
        mcycle("wd_hs");
        mcycle("wd_idle");
        #1;
        chk("wdog sticky", 64'(bus.wdog_err_o), 64'd1);
`endif

        // ---- randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid_i = 4'($urandom_range(0, 15));
            bus.out_ready_i = ((c % 64) < 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus.req_data_i  = randdata();
            mcycle($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
